// File: rtl/tm1637_display.sv
// TM1637 LED driver: bit-bangs one full display refresh (data command, address +
// segment bytes, display control) over the two-wire CLK/DIO bus per start request.
module tm1637_display #(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 250,
    parameter int ACK_CHECK  = 1
) (
    input  logic                    clk_50M,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [8*NUM_DIGITS-1:0] seg_data,
    input  logic [2:0]              brightness,
    input  logic                    display_on,
    output logic                    busy,
    output logic                    done,
    output logic                    ack_err,
    output logic                    tm1637_clk,
    output logic                    tm1637_dio_out,
    output logic                    tm1637_dio_oe,
    input  logic                    tm1637_dio_in,
    output logic [3:0]              debug
);

    typedef enum logic [3:0] {
        S_IDLE, S_START_A, S_START_B, S_BIT_LO, S_BIT_HI,
        S_ACK_LO, S_ACK_HI, S_STOP_A, S_STOP_B, S_STOP_C
    } state_e;

    typedef enum logic [1:0] {FR_CMD, FR_DATA, FR_DISP} frame_e;

    localparam int              BW             = $clog2(NUM_DIGITS + 1);
    localparam logic [15:0]     DIV_LAST       = 16'(CLK_DIV - 1);
    localparam logic [BW-1:0]   LAST_DATA_BYTE = BW'(NUM_DIGITS);

    state_e                    state_q, state_d;
    frame_e                    frame_q, frame_d;
    logic [15:0]               div_q, div_d;
    logic [2:0]                bit_q, bit_d;
    logic [BW-1:0]             byte_q, byte_d;
    logic [8*NUM_DIGITS-1:0]   seg_q, seg_d;
    logic [2:0]                bri_q, bri_d;
    logic                      on_q, on_d;
    logic                      ack_err_q, ack_err_d;
    logic                      done_q, done_d;
    logic                      busy_q, busy_d;
    logic                      scl_q, scl_d;
    logic                      oe_q, oe_d;
    logic                      out_q, out_d;
    logic                      tick;
    logic [BW-1:0]             last_byte;
    logic [7:0]                tx_byte;

    // Bus levels per phase, packed as {clk, oe, dio_out}.
    function automatic logic [2:0] bus_drive(input state_e s, input logic b);
        case (s)
            S_START_A: bus_drive = 3'b110;
            S_START_B: bus_drive = 3'b010;
            S_BIT_LO:  bus_drive = {2'b01, b};
            S_BIT_HI:  bus_drive = {2'b11, b};
            S_ACK_LO:  bus_drive = 3'b000;
            S_ACK_HI:  bus_drive = 3'b100;
            S_STOP_A:  bus_drive = 3'b010;
            S_STOP_B:  bus_drive = 3'b110;
            default:   bus_drive = 3'b100;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        state_d   = state_q;
        frame_d   = frame_q;
        bit_d     = bit_q;
        byte_d    = byte_q;
        seg_d     = seg_q;
        bri_d     = bri_q;
        on_d      = on_q;
        ack_err_d = ack_err_q;
        done_d    = 1'b0;
        tick      = (state_q != S_IDLE) && (div_q == DIV_LAST);
        div_d     = div_q;
        last_byte = (frame_q == FR_DATA) ? LAST_DATA_BYTE : '0;

        if (state_q != S_IDLE) begin
            div_d = tick ? 16'd0 : div_q + 16'd1;
        end

        if (state_q == S_IDLE) begin
            if (start) begin
                state_d   = S_START_A;
                frame_d   = FR_CMD;
                div_d     = 16'd0;
                bit_d     = 3'd0;
                byte_d    = '0;
                seg_d     = seg_data;
                bri_d     = brightness;
                on_d      = display_on;
                ack_err_d = 1'b0;
            end
        end else if (tick) begin
            case (state_q)
                S_START_A: state_d = S_START_B;
                S_START_B: state_d = S_BIT_LO;
                S_BIT_LO:  state_d = S_BIT_HI;
                S_BIT_HI: begin
                    state_d = (bit_q == 3'd7) ? S_ACK_LO : S_BIT_LO;
                    bit_d   = bit_q + 3'd1;
                end
                S_ACK_LO:  state_d = S_ACK_HI;
                S_ACK_HI: begin
                    // A missing ACK is only recorded; the refresh still runs to completion.
                    if ((ACK_CHECK != 0) && tm1637_dio_in) ack_err_d = 1'b1;
                    if (byte_q == last_byte) begin
                        state_d = S_STOP_A;
                    end else begin
                        state_d = S_BIT_LO;
                        byte_d  = byte_q + BW'(1);
                    end
                end
                S_STOP_A:  state_d = S_STOP_B;
                S_STOP_B:  state_d = S_STOP_C;
                S_STOP_C: begin
                    byte_d = '0;
                    if (frame_q == FR_DISP) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_START_A;
                        frame_d = (frame_q == FR_CMD) ? FR_DATA : FR_DISP;
                    end
                end
                default:   state_d = S_IDLE;
            endcase
        end

        // Byte index 0 of the data frame is the 0xC0 address; digits follow.
        tx_byte = 8'h40;
        case (frame_d)
            FR_CMD:  tx_byte = 8'h40;
            FR_DATA: begin
                tx_byte = 8'hC0;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (byte_d == BW'(i + 1)) tx_byte = seg_q[8*i +: 8];
                end
            end
            default: tx_byte = {4'h8, on_q, bri_q};
        endcase

        {scl_d, oe_d, out_d} = bus_drive(state_d, tx_byte[bit_d]);
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_50M or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            frame_q   <= FR_CMD;
            div_q     <= 16'd0;
            bit_q     <= 3'd0;
            byte_q    <= '0;
            seg_q     <= '0;
            bri_q     <= 3'd0;
            on_q      <= 1'b0;
            ack_err_q <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            scl_q     <= 1'b1;
            oe_q      <= 1'b0;
            out_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            frame_q   <= frame_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            byte_q    <= byte_d;
            seg_q     <= seg_d;
            bri_q     <= bri_d;
            on_q      <= on_d;
            ack_err_q <= ack_err_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            scl_q     <= scl_d;
            oe_q      <= oe_d;
            out_q     <= out_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign ack_err        = ack_err_q;
    assign tm1637_clk     = scl_q;
    assign tm1637_dio_oe  = oe_q;
    assign tm1637_dio_out = out_q;
    assign debug          = state_q;

endmodule
